// File: rtl/turbo_deframer.sv
// Receive-side deframer for the turbo encoder output stream: splits frames into
// data + tail symbols, double-buffers them and presents each block for random access.
module turbo_deframer #(
  parameter int K_LONG    = 6144,
  parameter int K_SHORT   = 1056,
  parameter int AW        = 13,
  parameter int TAIL_SYMS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_len,
  input  logic                   xk,
  input  logic                   zk,
  input  logic                   zkp,
  output logic                   blk_ready,
  output logic                   blk_len,
  output logic [3*TAIL_SYMS-1:0] blk_tail,
  input  logic [AW-1:0]          rd_addr,
  output logic [2:0]             rd_data,
  input  logic                   blk_done,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);
  localparam int TW  = 3 * TAIL_SYMS;
  localparam int TCW = $clog2(TAIL_SYMS);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, TAIL = 2'd2, DROP = 2'd3;
  localparam logic [AW-1:0] K_L = AW'(K_LONG);
  localparam logic [AW-1:0] K_S = AW'(K_SHORT);

  logic [1:0]          state;
  logic                len_q;
  logic [AW-1:0]       cnt;
  logic [TCW-1:0]      tcnt;
  logic [1:0]          full;
  logic                wptr, rptr;
  logic [1:0]          bank_len;
  logic [1:0][TW-1:0]  bank_tail;
  logic [2:0]          mem0 [K_LONG];
  logic [2:0]          mem1 [K_LONG];

  logic [2:0]    sym;
  logic [AW-1:0] k_cur;
  logic          release_blk, wbank_busy, start_ok, tail_last, we;
  logic [AW-1:0] waddr;

  assign sym         = {zkp, zk, xk};
  assign k_cur       = len_q ? K_L : K_S;
  assign release_blk = blk_done & full[rptr];
  // A release on the same edge frees the write bank before the full check sees it.
  assign wbank_busy  = full[wptr] & ~(release_blk & (rptr == wptr));
  assign start_ok    = in_valid & (state == IDLE) & ~wbank_busy;
  assign tail_last   = in_valid & (state == TAIL) & (tcnt == TCW'(TAIL_SYMS - 1));
  assign we          = start_ok | (in_valid & (state == DATA));
  assign waddr       = (state == IDLE) ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= 1'b0;
      cnt      <= '0;
      tcnt     <= '0;
      wptr     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (in_valid) begin
      case (state)
        IDLE: begin
          len_q <= in_len;
          cnt   <= AW'(1);
          if (wbank_busy) begin
            state    <= DROP;
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          if (cnt == k_cur - AW'(1)) begin
            cnt   <= '0;
            tcnt  <= '0;
            state <= TAIL;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        TAIL: begin
          tcnt <= tcnt + TCW'(1);
          if (tail_last) begin
            wptr  <= ~wptr;
            state <= IDLE;
          end
        end
        DROP: begin
          // cnt is the index of the symbol being discarded; the frame ends at K+TAIL_SYMS-1
          if (cnt == k_cur + AW'(TAIL_SYMS - 1)) state <= IDLE;
          else cnt <= cnt + AW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      rptr      <= 1'b0;
      bank_len  <= '0;
      bank_tail <= '0;
    end else begin
      if (release_blk) begin
        full[rptr] <= 1'b0;
        rptr       <= ~rptr;
      end
      if (in_valid && state == TAIL) bank_tail[wptr][3*tcnt +: 3] <= sym;
      if (tail_last) begin
        full[wptr]     <= 1'b1;
        bank_len[wptr] <= len_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we && !wptr) mem0[waddr] <= sym;
    if (we &&  wptr) mem1[waddr] <= sym;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rptr ? mem1[rd_addr] : mem0[rd_addr];
  end

  assign blk_ready = full[rptr];
  assign blk_len   = bank_len[rptr];
  assign blk_tail  = bank_tail[rptr];
endmodule

// File: tb/tb_turbo_deframer.sv
// Bench for turbo_deframer: table of frame scenarios, hand-written corner sequences
// and a randomized run against a block-queue reference model.
module tb_turbo_deframer;
  localparam int K_LONG = 6144, K_SHORT = 1056, AW = 13;

  logic clk = 1'b0;
  logic rst, in_valid, in_len, xk, zk, zkp;
  logic blk_ready, blk_len, blk_done, overflow;
  logic [11:0] blk_tail;
  logic [AW-1:0] rd_addr;
  logic [2:0] rd_data;
  logic [7:0] drop_cnt;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  turbo_deframer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_len(in_len),
    .xk(xk), .zk(zk), .zkp(zkp),
    .blk_ready(blk_ready), .blk_len(blk_len), .blk_tail(blk_tail),
    .rd_addr(rd_addr), .rd_data(rd_data), .blk_done(blk_done),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic len; bit tog; int gd; int gt; logic [11:0] tail; int seed;
    logic e_before; logic e_ready; logic e_len; logic [11:0] e_tail;
    logic e_ovf; int e_drop; int v_seed; int done_after;
  } vec_t;

  typedef struct { int seed; logic len; logic [11:0] tail; } blk_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Seed 0 gives symbol n = n mod 8; other seeds give a scrambled pattern.
  function automatic logic [2:0] fsym(input int seed, input int n);
    logic [31:0] v;
    if (seed == 0) return 3'(n);
    v = 32'(n * (2 * seed + 1) + (n >> 4) * seed);
    return v[2:0] ^ v[6:4];
  endfunction

  task automatic idle_cycle();
    in_valid = 1'b0;
    blk_done = 1'b0;
    {zkp, zk, xk} = 3'($urandom);
    in_len = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic pulse_done();
    blk_done = 1'b1;
    @(negedge clk);
    blk_done = 1'b0;
  endtask

  task automatic send_frame(input logic len, input int seed, input logic [11:0] tail,
                            input int gd, input int gt, input bit tog,
                            input int done_at, input int rst_at, output logic rdy_before);
    int k;
    logic [11:0] t;
    k = len ? K_LONG : K_SHORT;
    t = tail;
    rdy_before = 1'b0;
    for (int n = 0; n < k + 4; n++) begin
      if (n == 500) repeat (gd) idle_cycle();
      if (n == k + 2) repeat (gt) idle_cycle();
      in_valid = 1'b1;
      in_len = (tog && n[0]) ? ~len : len;
      {zkp, zk, xk} = (n < k) ? fsym(seed, n) : t[3*(n-k) +: 3];
      blk_done = (n == done_at);
      rst = (n == rst_at);
      if (n == k + 3) rdy_before = blk_ready;
      @(negedge clk);
      if (n == rst_at) break;
    end
    in_valid = 1'b0;
    blk_done = 1'b0;
    rst = 1'b0;
  endtask

  // nsamp=0 reads every address in order; otherwise nsamp random addresses.
  task automatic read_block(input string name, input int seed, input int k, input int nsamp);
    int bad, cnt, a, prev, ba;
    logic [2:0] bg, be;
    bad = 0; prev = -1; a = 0; ba = 0; bg = '0; be = '0;
    cnt = (nsamp > 0) ? nsamp : k;
    for (int i = 0; i <= cnt; i++) begin
      if (i < cnt) begin
        a = (nsamp > 0) ? int'($urandom_range(k - 1, 0)) : i;
        rd_addr = AW'(a);
      end
      #1;
      if (prev >= 0 && rd_data !== fsym(seed, prev)) begin
        if (bad == 0) begin ba = prev; bg = rd_data; be = fsym(seed, prev); end
        bad++;
      end
      prev = (i < cnt) ? a : -1;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s data: %0d bad reads, first addr %0d got %0h expected %0h", name, bad, ba, bg, be);
    end
  endtask

  task automatic chk_state(input string name, input logic r, input logic l, input logic [11:0] t,
                           input logic o, input int d);
    chk({name, " ready"}, 32'(blk_ready), 32'(r));
    if (r) begin
      chk({name, " len"}, 32'(blk_len), 32'(l));
      chk({name, " tail"}, 32'(blk_tail), 32'(t));
    end
    chk({name, " overflow"}, 32'(overflow), 32'(o));
    chk({name, " drop_cnt"}, 32'(drop_cnt), 32'(d));
  endtask

  task automatic chk_reset(input string name);
    chk({name, " ready"}, 32'(blk_ready), 32'(0));
    chk({name, " len"}, 32'(blk_len), 32'(0));
    chk({name, " tail"}, 32'(blk_tail), 32'(0));
    chk({name, " rd_data"}, 32'(rd_data), 32'(0));
    chk({name, " overflow"}, 32'(overflow), 32'(0));
    chk({name, " drop_cnt"}, 32'(drop_cnt), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[5];
    blk_t q[$];
    blk_t nb;
    logic rb;
    int m_drop, seed, n, k, gap;
    bit m_ovf, dropping, v, d;
    logic [11:0] tail;

    tbl[0] = '{1'b0, 1'b0, 0, 0, 12'hA5C, 0, 1'b0, 1'b1, 1'b0, 12'hA5C, 1'b0, 0, 0, 1};
    tbl[1] = '{1'b1, 1'b1, 0, 0, 12'h3E7, 1, 1'b0, 1'b1, 1'b1, 12'h3E7, 1'b0, 0, 1, 1};
    tbl[2] = '{1'b0, 1'b0, 5, 2, 12'h5A3, 0, 1'b0, 1'b1, 1'b0, 12'h5A3, 1'b0, 0, 0, 0};
    tbl[3] = '{1'b0, 1'b0, 0, 0, 12'h111, 2, 1'b1, 1'b1, 1'b0, 12'h5A3, 1'b0, 0, -1, 0};
    tbl[4] = '{1'b0, 1'b0, 0, 0, 12'h222, 3, 1'b1, 1'b1, 1'b0, 12'h5A3, 1'b1, 1, -1, 1};

    rst = 1'b1; in_valid = 1'b0; in_len = 1'b0; xk = 1'b0; zk = 1'b0; zkp = 1'b0;
    blk_done = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");

    foreach (tbl[i]) begin
      send_frame(tbl[i].len, tbl[i].seed, tbl[i].tail, tbl[i].gd, tbl[i].gt, tbl[i].tog, -1, -1, rb);
      chk($sformatf("vec%0d ready_before_last", i), 32'(rb), 32'(tbl[i].e_before));
      chk_state($sformatf("vec%0d", i), tbl[i].e_ready, tbl[i].e_len, tbl[i].e_tail,
                tbl[i].e_ovf, tbl[i].e_drop);
      if (tbl[i].v_seed >= 0)
        read_block($sformatf("vec%0d", i), tbl[i].v_seed, tbl[i].len ? K_LONG : K_SHORT, 0);
      repeat (tbl[i].done_after) pulse_done();
    end

    // Second buffered frame takes over after the first release
    chk_state("after_drop_release", 1'b1, 1'b0, 12'h111, 1'b1, 1);
    read_block("frame2", 2, K_SHORT, 0);

    send_frame(1'b0, 4, 12'h444, 0, 0, 1'b0, -1, -1, rb);
    chk_state("A_buffered", 1'b1, 1'b0, 12'h111, 1'b1, 1);
    pulse_done();
    chk_state("A_presented", 1'b1, 1'b0, 12'h444, 1'b1, 1);

    // Release of A on the same edge as B's final tail symbol
    send_frame(1'b0, 5, 12'h555, 0, 0, 1'b0, K_SHORT + 3, -1, rb);
    chk_state("B_same_edge", 1'b1, 1'b0, 12'h555, 1'b1, 1);
    read_block("B", 5, K_SHORT, 0);
    send_frame(1'b0, 6, 12'h666, 0, 0, 1'b0, -1, -1, rb);
    chk_state("C_accepted", 1'b1, 1'b0, 12'h555, 1'b1, 1);
    pulse_done();
    chk_state("C_presented", 1'b1, 1'b0, 12'h666, 1'b1, 1);
    read_block("C", 6, K_SHORT, 0);

    // Frame start on the same edge that frees the write bank
    send_frame(1'b0, 7, 12'h777, 0, 0, 1'b0, -1, -1, rb);
    send_frame(1'b0, 8, 12'h888, 0, 0, 1'b0, 0, -1, rb);
    chk_state("E_start_release", 1'b1, 1'b0, 12'h777, 1'b1, 1);
    pulse_done();
    chk_state("E_presented", 1'b1, 1'b0, 12'h888, 1'b1, 1);
    read_block("E", 8, K_SHORT, 200);
    pulse_done();
    chk("all_released ready", 32'(blk_ready), 32'(0));
    pulse_done();
    chk("idle_done ignored", 32'(blk_ready), 32'(0));

    // Reset in the middle of a frame
    send_frame(1'b0, 9, 12'h999, 0, 0, 1'b0, -1, 500, rb);
    chk_reset("midframe_reset");
    send_frame(1'b0, 10, 12'hABC, 0, 0, 1'b0, -1, -1, rb);
    chk("F ready_before_last", 32'(rb), 32'(0));
    chk_state("F_after_reset", 1'b1, 1'b0, 12'hABC, 1'b0, 0);
    read_block("F", 10, K_SHORT, 0);
    pulse_done();

    // Randomized run against a queue of presented blocks (capacity 2)
    m_drop = 0; m_ovf = 1'b0;
    for (int f = 0; f < 8; f++) begin
      seed = int'($urandom_range(1000, 11));
      tail = 12'($urandom);
      k = K_SHORT;
      n = 0;
      dropping = 1'b0;
      while (n < k + 4) begin
        v = ($urandom % 4) != 0;
        d = ($urandom % 1200) == 0;
        in_valid = v;
        blk_done = d;
        in_len = (n == 0) ? 1'b0 : 1'($urandom);
        {zkp, zk, xk} = !v ? 3'($urandom) : (n < k) ? fsym(seed, n) : tail[3*(n-k) +: 3];
        if (d && q.size() > 0) void'(q.pop_front());
        if (v) begin
          if (n == 0) begin
            dropping = (q.size() == 2);
            if (dropping) begin
              m_ovf = 1'b1;
              if (m_drop < 255) m_drop++;
            end
          end
          if (n == k + 3 && !dropping) begin
            nb.seed = seed; nb.len = 1'b0; nb.tail = tail;
            q.push_back(nb);
          end
          n++;
        end
        @(negedge clk);
        chk("rnd ready", 32'(blk_ready), 32'(q.size() > 0));
        if (q.size() > 0) begin
          chk("rnd tail", 32'(blk_tail), 32'(q[0].tail));
          chk("rnd len", 32'(blk_len), 32'(q[0].len));
        end
      end
      in_valid = 1'b0;
      blk_done = 1'b0;
      chk("rnd overflow", 32'(overflow), 32'(m_ovf));
      chk("rnd drop_cnt", 32'(drop_cnt), 32'(m_drop));
      if (q.size() > 0) read_block("rnd head", q[0].seed, K_SHORT, 32);
      gap = int'($urandom_range(3, 0));
      repeat (gap) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
